adc_capture_mc: RTL and testbench

Parametrised multi-channel serial-ADC capture engine with an APB3 slave. It is the successor to the fixed two-pixel-ADC capture path. It drives one shared CS_N/SCLK pair and receives NUM_CH parallel DIN lines (ADCS7476-style frames). Samples are buffered in an internal FIFO that firmware drains over APB. Adds multi-frame burst mode, continuous mode, abort, flush, overflow accounting and an interrupt.

---
 rtl/adc_capture_pkg.sv | 39 +++
 rtl/adc_capture_fifo.sv | 56 +++++
 rtl/adc_capture_mc.sv | 254 +++++++++++++++++++++++++
 tb/tb_adc_capture_mc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the multi-channel serial-ADC capture engine:
// register map, control/status bit positions, FSM states and DATA word layout.
package adc_capture_pkg;

  localparam logic [4:0] AddrCtrl   = 5'h00;
  localparam logic [4:0] AddrCount  = 5'h04;
  localparam logic [4:0] AddrStatus = 5'h08;
  localparam logic [4:0] AddrData   = 5'h0C;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlCont  = 1;
  localparam int unsigned CtrlFlush = 2;
  localparam int unsigned CtrlIrqEn = 3;
  localparam int unsigned CtrlAbort = 4;

  localparam int unsigned StatBusy  = 0;
  localparam int unsigned StatFull  = 1;
  localparam int unsigned StatEmpty = 2;
  localparam int unsigned StatOvf   = 3;
  localparam int unsigned StatDone  = 4;

  localparam int unsigned DataFrameLsb = 24;
  localparam int unsigned DataChLsb    = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StPush,
    StQuiet
  } state_e;

  function automatic logic [31:0] pack_data(input logic [7:0]  frame,
                                            input logic [7:0]  ch,
                                            input logic [15:0] sample);
    return {frame, ch, sample};
  endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// Synchronous sample FIFO with level, flush and a drop indication for pushes
// that find no free slot.
module adc_capture_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~flush_i & full_o & ~do_pop;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/adc_capture_mc.sv
// Multi-channel serial-ADC capture engine: shared CS_N/SCLK frame sequencer,
// per-channel shift registers, sample FIFO and APB3 register interface.
module adc_capture_mc
  import adc_capture_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SAMPLE_W   = 12,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned LEAD_BITS  = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [4:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] adc_din,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              irq,
  output logic              tp_conv_complete,
  output logic              fifo_full,
  output logic              fifo_empty
);

  localparam int unsigned DivW   = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);
  localparam int unsigned ChW    = $clog2(NUM_CH + 1);
  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);

  state_e              state_q;
  logic [DivW-1:0]     div_q;
  logic [BitW-1:0]     bit_q;
  logic [ChW-1:0]      ch_q;
  logic [15:0]         frames_q, count_q;
  logic [7:0]          frame_idx_q, ovf_cnt_q;
  logic [FRAME_BITS-1:0] sr_q [NUM_CH];
  logic cs_n_q, sclk_q, tp_q, cont_q, irq_en_q, ovf_q, done_q, irq_q, data_hit_q;
  logic [31:0] prdata_q, rd_data, push_word;
  logic [15:0] push_sample;
  logic [FifoAw:0] fifo_level;
  logic [31:0] fifo_rdata;
  logic apb_setup, apb_wr, apb_rd, wr_ctrl, wr_count, wr_status;
  logic start_p, flush_p, abort_p, pop, push_en, fifo_drop;
  logic busy, more, quiet_end, done_set;
  logic unused_pwdata, unused_sr;

  assign apb_setup = PSEL & ~PENABLE;
  assign apb_wr    = PSEL & PENABLE & PWRITE;
  assign apb_rd    = PSEL & PENABLE & ~PWRITE;
  assign wr_ctrl   = apb_wr && (PADDR == AddrCtrl);
  assign wr_count  = apb_wr && (PADDR == AddrCount);
  assign wr_status = apb_wr && (PADDR == AddrStatus);
  assign start_p   = wr_ctrl & PWDATA[CtrlStart];
  assign flush_p   = wr_ctrl & PWDATA[CtrlFlush];
  assign abort_p   = wr_ctrl & PWDATA[CtrlAbort];
  // Pop only if the setup phase actually returned a head word.
  assign pop       = apb_rd && (PADDR == AddrData) && data_hit_q;

  assign busy      = (state_q != StIdle);
  assign more      = cont_q | (frames_q != '0);
  assign quiet_end = (div_q == DivW'(2 * CLK_DIV - 1));
  assign done_set  = (state_q == StQuiet) & quiet_end & ~more & ~abort_p;
  assign push_en   = (state_q == StPush);

  always_comb begin
    push_sample = '0;
    unused_sr   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == ChW'(c)) push_sample = 16'(sr_q[c][FRAME_BITS-1-LEAD_BITS -: SAMPLE_W]);
      unused_sr = unused_sr ^ (^sr_q[c]);
    end
  end
  assign push_word     = pack_data(frame_idx_q, 8'(ch_q), push_sample);
  assign unused_pwdata = ^PWDATA[31:16];

  adc_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETN),
    .push_i  (push_en),
    .pop_i   (pop),
    .flush_i (flush_p),
    .wdata_i (push_word),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .level_o (fifo_level)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_q       <= '0;
      ch_q        <= '0;
      frames_q    <= '0;
      frame_idx_q <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      tp_q        <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) sr_q[c] <= '0;
    end else begin
      tp_q <= 1'b0;
      if (abort_p) begin
        state_q <= StIdle;
        cs_n_q  <= 1'b1;
        sclk_q  <= 1'b1;
        div_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_p && ((count_q != '0) || PWDATA[CtrlCont])) begin
              frames_q    <= count_q;
              frame_idx_q <= '0;
              div_q       <= '0;
              cs_n_q      <= 1'b0;
              sclk_q      <= 1'b1;
              state_q     <= StSetup;
            end
          end
          StSetup: begin
            if (div_q == DivW'(CLK_DIV - 1)) begin
              div_q   <= '0;
              bit_q   <= '0;
              sclk_q  <= 1'b0;
              state_q <= StShift;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          StShift: begin
            if (div_q == DivW'(CLK_DIV - 1)) begin
              div_q <= '0;
              if (!sclk_q) begin
                sclk_q <= 1'b1;
                for (int c = 0; c < NUM_CH; c++) sr_q[c] <= {sr_q[c][FRAME_BITS-2:0], adc_din[c]};
              end else if (bit_q == BitW'(FRAME_BITS - 1)) begin
                ch_q    <= '0;
                tp_q    <= 1'b1;
                state_q <= StPush;
              end else begin
                sclk_q <= 1'b0;
                bit_q  <= bit_q + 1'b1;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          StPush: begin
            if (ch_q == ChW'(NUM_CH - 1)) begin
              div_q       <= '0;
              cs_n_q      <= 1'b1;
              frames_q    <= (frames_q != '0) ? frames_q - 1'b1 : frames_q;
              frame_idx_q <= frame_idx_q + 1'b1;
              state_q     <= StQuiet;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end
          StQuiet: begin
            if (quiet_end) begin
              div_q <= '0;
              if (more) begin
                cs_n_q  <= 1'b0;
                state_q <= StSetup;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= '0;
      data_hit_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        cont_q   <= PWDATA[CtrlCont];
        irq_en_q <= PWDATA[CtrlIrqEn];
      end
      if (wr_count) count_q <= PWDATA[15:0];
      if (wr_status && PWDATA[StatOvf]) begin
        ovf_q     <= 1'b0;
        ovf_cnt_q <= '0;
      end
      if (fifo_drop) begin
        ovf_q     <= 1'b1;
        ovf_cnt_q <= (ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
      end
      if (wr_status && PWDATA[StatDone]) done_q <= 1'b0;
      if (done_set) done_q <= 1'b1;
      irq_q <= irq_en_q & (done_q | ovf_q);
      if (apb_setup) begin
        prdata_q   <= rd_data;
        data_hit_q <= (PADDR == AddrData) && !fifo_empty;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (PADDR)
      AddrCtrl: begin
        rd_data[CtrlCont]  = cont_q;
        rd_data[CtrlIrqEn] = irq_en_q;
      end
      AddrCount: rd_data[15:0] = count_q;
      AddrStatus: begin
        rd_data[StatBusy]  = busy;
        rd_data[StatFull]  = fifo_full;
        rd_data[StatEmpty] = fifo_empty;
        rd_data[StatOvf]   = ovf_q;
        rd_data[StatDone]  = done_q;
        rd_data[15:8]      = ovf_cnt_q;
        rd_data[31:16]     = 16'(fifo_level);
      end
      AddrData: rd_data = fifo_empty ? 32'h0 : fifo_rdata;
      default: rd_data = '0;
    endcase
  end

  assign PRDATA           = prdata_q;
  assign PREADY           = 1'b1;
  assign PSLVERR          = 1'b0;
  assign adc_cs_n         = cs_n_q;
  assign adc_sclk         = sclk_q;
  assign irq              = irq_q;
  assign tp_conv_complete = tp_q;

endmodule

// File: tb/tb_adc_capture_mc.sv
// Bench for adc_capture_mc: register table, frame capture via a modelled ADC,
// FIFO overflow/flush/abort corners, checked against an expected-word queue.
module tb_adc_capture_mc;

  localparam logic [4:0] ACtrl = 5'h00, ACount = 5'h04, AStat = 5'h08, AData = 5'h0C;

  logic        PCLK = 1'b0, PRESETN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [4:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  adc_din = '0;
  logic        adc_cs_n, adc_sclk, irq, tp_conv_complete, fifo_full, fifo_empty;

  int total = 0, bad = 0;
  int fall_cnt = 0, bit_base = 0, cs_rise_cnt = 0, frame_base = 0, tp_cnt = 0;
  logic tp_at_access;
  logic [31:0] sb[$];

  adc_capture_mc #(
    .NUM_CH(2), .SAMPLE_W(12), .FRAME_BITS(16), .LEAD_BITS(4), .CLK_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .adc_din(adc_din), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .irq(irq),
    .tp_conv_complete(tp_conv_complete), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 PCLK = ~PCLK;

  // ADC model: frame f of channel ch carries lead bits f*5 and a per-frame sample.
  function automatic logic [11:0] samp(input int ch, input int f);
    return (ch == 1) ? 12'h123 + 12'(f * 'h22) : 12'hABC + 12'(f * 'h11);
  endfunction
  function automatic logic bit_of(input int ch, input int f, input int idx);
    logic [15:0] w;
    w = {4'(f * 5), samp(ch, f)};
    return w[15 - idx];
  endfunction
  function automatic logic [31:0] exp_word(input int f, input int ch);
    return {8'(f), 8'(ch), 4'h0, samp(ch, f)};
  endfunction

  always @(negedge adc_sclk) begin
    if (!adc_cs_n) begin
      adc_din  <= {bit_of(1, cs_rise_cnt - frame_base, fall_cnt - bit_base),
                   bit_of(0, cs_rise_cnt - frame_base, fall_cnt - bit_base)};
      fall_cnt <= fall_cnt + 1;
    end
  end
  always @(negedge adc_cs_n) bit_base <= fall_cnt;
  always @(posedge adc_cs_n) cs_rise_cnt <= cs_rise_cnt + 1;
  always @(posedge PCLK) if (tp_conv_complete) tp_cnt <= tp_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    d = PRDATA;
    tp_at_access = tp_conv_complete;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  task automatic check_data(input string name);
    logic [31:0] d, e;
    e = (sb.size() == 0) ? 32'h0 : sb.pop_front();
    apb_read(AData, d);
    check(name, d, e);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n = 0;
    do begin
      apb_read(AStat, s);
      n++;
    end while (s[0] && n < 400);
    check(name, {31'h0, s[0]}, 32'h0);
  endtask

  task automatic wait_tp(input string name);
    int n = 0;
    do begin
      @(posedge PCLK); #1;
      n++;
    end while (!tp_conv_complete && n < 400);
    check(name, {31'h0, tp_conv_complete}, 32'h1);
  endtask

  task automatic wait_falls(input string name, input int k);
    int base = fall_cnt, n = 0;
    while ((fall_cnt - base) < k && n < 400) begin
      @(posedge PCLK); #1;
      n++;
    end
    check(name, 32'(fall_cnt - base), 32'(k));
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t0, f0;
    vecs[0] = '{1'b1, ACount, 32'h0000_1234, 32'h0000_1234, "count_rw"};
    vecs[1] = '{1'b1, ACount, 32'hFFFF_0005, 32'h0000_0005, "count_16b"};
    vecs[2] = '{1'b1, ACtrl,  32'h0000_000A, 32'h0000_000A, "ctrl_cont_irqen"};
    vecs[3] = '{1'b1, ACtrl,  32'h0000_0000, 32'h0000_0000, "ctrl_clear"};
    vecs[4] = '{1'b0, AStat,  32'h0,         32'h0000_0004, "status_reset"};
    vecs[5] = '{1'b1, 5'h10,  32'hDEAD_BEEF, 32'h0000_0000, "unmapped_10"};
    vecs[6] = '{1'b1, 5'h14,  32'hDEAD_BEEF, 32'h0000_0000, "unmapped_14"};
    vecs[7] = '{1'b0, AData,  32'h0,         32'h0000_0000, "data_empty"};

    #12;
    check("rst_cs_n", {31'h0, adc_cs_n}, 32'h1);
    check("rst_sclk", {31'h0, adc_sclk}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_tp", {31'h0, tp_conv_complete}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_empty_full", {30'h0, fifo_empty, fifo_full}, 32'h2);
    @(negedge PCLK) PRESETN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].wdata);
      check_reg(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Single frame, two channels.
    apb_write(ACount, 32'd1);
    frame_base = cs_rise_cnt; t0 = tp_cnt; f0 = fall_cnt;
    apb_write(ACtrl, 32'h1);
    wait_idle("single_idle");
    check("single_tp_pulses", 32'(tp_cnt - t0), 32'd1);
    check("single_sclk_falls", 32'(fall_cnt - f0), 32'd16);
    check_reg("single_status", AStat, 32'h0002_0010);
    sb.push_back(32'h0000_0ABC);
    sb.push_back(32'h0001_0123);
    check_data("single_ch0");
    check_data("single_ch1");
    apb_write(AStat, 32'h10);

    // Three-frame burst with irq, drained as it runs.
    apb_write(ACount, 32'd3);
    frame_base = cs_rise_cnt;
    apb_write(ACtrl, 32'h9);
    for (int f = 0; f < 3; f++) begin
      wait_tp("burst_tp");
      if (f == 0) check("burst_irq_mid", {31'h0, irq}, 32'h0);
      sb.push_back(exp_word(f, 0));
      sb.push_back(exp_word(f, 1));
      repeat (4) @(posedge PCLK);
      #1;
      check_data("burst_ch0");
      check_data("burst_ch1");
    end
    wait_idle("burst_idle");
    check("burst_irq_set", {31'h0, irq}, 32'h1);
    check_reg("burst_status", AStat, 32'h0000_0014);
    apb_write(AStat, 32'h10);
    @(posedge PCLK); #1;
    check("burst_irq_clr", {31'h0, irq}, 32'h0);

    // Overflow: three frames into a 4-deep FIFO with no reads.
    frame_base = cs_rise_cnt;
    apb_write(ACtrl, 32'h1);
    for (int f = 0; f < 2; f++) begin
      sb.push_back(exp_word(f, 0));
      sb.push_back(exp_word(f, 1));
    end
    wait_idle("ovf_idle");
    check_reg("ovf_status", AStat, 32'h0004_021A);
    check("ovf_full_pin", {31'h0, fifo_full}, 32'h1);
    check("ovf_irq_gated", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) check_data("ovf_word");
    check_reg("ovf_drained", AStat, 32'h0000_021C);
    apb_write(AStat, 32'h18);
    check_reg("ovf_w1c", AStat, 32'h0000_0004);

    // Pop while full, coincident with the channel-0 push of a new frame.
    apb_write(ACount, 32'd2);
    frame_base = cs_rise_cnt;
    apb_write(ACtrl, 32'h1);
    for (int f = 0; f < 2; f++) begin
      sb.push_back(exp_word(f, 0));
      sb.push_back(exp_word(f, 1));
    end
    wait_idle("pp_fill_idle");
    check_reg("pp_fill_status", AStat, 32'h0004_0012);
    apb_write(AStat, 32'h10);
    apb_write(ACount, 32'd1);
    frame_base = cs_rise_cnt;
    apb_write(ACtrl, 32'h1);
    repeat (64) @(posedge PCLK);
    check_data("pp_pop_word");
    check("pp_pop_aligned", {31'h0, tp_at_access}, 32'h1);
    sb.push_back(exp_word(0, 0));
    wait_idle("pp_idle");
    check_reg("pp_status", AStat, 32'h0004_011A);
    for (int i = 0; i < 4; i++) check_data("pp_word");
    apb_write(AStat, 32'h18);

    // Continuous mode cleared mid-frame: the frame completes, then idle.
    apb_write(ACount, 32'd0);
    frame_base = cs_rise_cnt;
    apb_write(ACtrl, 32'h3);
    wait_falls("cont_falls", 3);
    apb_write(ACtrl, 32'h0);
    wait_idle("cont_idle");
    check_reg("cont_status", AStat, 32'h0002_0010);
    sb.push_back(exp_word(0, 0));
    sb.push_back(exp_word(0, 1));
    apb_write(AStat, 32'h10);

    // Abort in bit 7 keeps FIFO contents; flush then empties it.
    apb_write(ACount, 32'd1);
    frame_base = cs_rise_cnt;
    apb_write(ACtrl, 32'h1);
    wait_falls("abort_falls", 8);
    apb_write(ACtrl, 32'h10);
    check("abort_cs_sclk", {30'h0, adc_cs_n, adc_sclk}, 32'h3);
    repeat (100) @(posedge PCLK);
    check_reg("abort_status", AStat, 32'h0002_0000);
    apb_write(ACtrl, 32'h4);
    sb.delete();
    check_reg("flush_status", AStat, 32'h0000_0004);
    check("flush_empty_pin", {31'h0, fifo_empty}, 32'h1);

    check_data("empty_data");
    check_reg("empty_level", AStat, 32'h0000_0004);

    // Asynchronous reset mid-frame.
    frame_base = cs_rise_cnt;
    apb_write(ACtrl, 32'h1);
    wait_falls("arst_falls", 5);
    #3 PRESETN = 1'b0;
    #1 check("arst_cs_sclk", {30'h0, adc_cs_n, adc_sclk}, 32'h3);
    @(negedge PCLK) PRESETN = 1'b1;
    check_reg("arst_status", AStat, 32'h0000_0004);
    check_reg("arst_count", ACount, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
